// File: rtl/decode_packet.sv
// Reassembles NUMBER_PACKET Aurora flits into one DFX word (data + address) for the decode controller.
// Latency: dfx_valid rises 1 cycle after the last flit is accepted.
// Backpressure: ready_decode_pkt drops while a finished word waits for dfx_ready; no flit is taken during handoff.
module decode_packet #(
    parameter int DATA_WIDTH        = 1024,
    parameter int ADDR_WIDTH        = 10,
    parameter int DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH,
    parameter int NUMBER_PACKET     = 19,
    parameter int AURORA_DATA_WIDTH = 64,
    parameter int PAYLOAD_WIDTH     = 55
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         decode_valid,
    input  logic [AURORA_DATA_WIDTH-1:0] data_recv,
    output logic                         ready_decode_pkt,
    output logic                         dfx_valid,
    input  logic                         dfx_ready,
    output logic [DATA_DFX_WIDTH-1:0]    data_dfx_recv,
    output logic [1:0]                   dfx_src_router,
    output logic                         seq_error
);

    // The final flit only carries what is left of the word after the full slices.
    localparam int LAST_W = DATA_DFX_WIDTH - (NUMBER_PACKET - 1) * PAYLOAD_WIDTH;
    localparam logic [4:0] LAST_IDX = 5'(NUMBER_PACKET - 1);

    typedef enum logic {
        COLLECT,
        OUTPUT
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] exp_q, exp_d;
    logic [1:0] src_q, src_d;
    logic       flit_accept;
    logic       flit_good;
    logic       wr_en;
    logic       bad_flit;
    logic       frame_done;

    logic [PAYLOAD_WIDTH-1:0] flit_payload;
    logic [4:0]               flit_num;
    logic [1:0]               flit_src;
    logic                     unused_ttl;

    assign flit_payload = data_recv[AURORA_DATA_WIDTH-1:9];
    assign flit_num     = data_recv[6:2];
    assign flit_src     = data_recv[1:0];
    assign unused_ttl   = ^data_recv[8:7];

    assign flit_accept = decode_valid && ready_decode_pkt;
    // Index 0 opens a frame, so its source is the reference for the rest.
    assign flit_good   = (flit_num == exp_q) && ((exp_q == 5'd0) || (flit_src == src_q));

    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        src_d      = src_q;
        wr_en      = 1'b0;
        bad_flit   = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            COLLECT: begin
                if (flit_accept) begin
                    if (flit_good) begin
                        wr_en = 1'b1;
                        if (exp_q == 5'd0) begin
                            src_d = flit_src;
                        end
                        if (exp_q == LAST_IDX) begin
                            exp_d      = 5'd0;
                            state_d    = OUTPUT;
                            frame_done = 1'b1;
                        end else begin
                            exp_d = exp_q + 5'd1;
                        end
                    end else begin
                        bad_flit = 1'b1;
                        // A stray index 0 is most likely the start of a fresh frame: restart on it.
                        if (flit_num == 5'd0) begin
                            wr_en = 1'b1;
                            src_d = flit_src;
                            exp_d = 5'd1;
                        end else begin
                            exp_d = 5'd0;
                        end
                    end
                end
            end
            OUTPUT: begin
                if (dfx_valid && dfx_ready) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= COLLECT;
            exp_q            <= 5'd0;
            src_q            <= 2'd0;
            ready_decode_pkt <= 1'b0;
            dfx_valid        <= 1'b0;
            dfx_src_router   <= 2'd0;
            seq_error        <= 1'b0;
        end else begin
            state_q          <= state_d;
            exp_q            <= exp_d;
            src_q            <= src_d;
            ready_decode_pkt <= (state_d == COLLECT);
            dfx_valid        <= (state_d == OUTPUT);
            seq_error        <= bad_flit;
            if (frame_done) begin
                dfx_src_router <= src_d;
            end
        end
    end

    // Slices are written in place; stale bits from an aborted frame are overwritten by the next one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_dfx_recv <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < NUMBER_PACKET - 1; k++) begin
                if (flit_num == 5'(k)) begin
                    data_dfx_recv[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] <= flit_payload;
                end
            end
            if (flit_num == LAST_IDX) begin
                data_dfx_recv[DATA_DFX_WIDTH-1 -: LAST_W] <= data_recv[9 +: LAST_W];
            end
        end
    end

endmodule

// File: tb/tb_decode_packet.sv
// Directed bench for decode_packet: frame reassembly, backpressure, sequence/source errors, reset and gaps.
module tb_decode_packet;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          decode_valid;
    logic [63:0]   data_recv;
    logic          ready_decode_pkt;
    logic          dfx_valid;
    logic          dfx_ready;
    logic [1033:0] data_dfx_recv;
    logic [1:0]    dfx_src_router;
    logic          seq_error;

    int n_chk  = 0;
    int n_fail = 0;
    int dfx_cycles = 0;
    int seq_cycles = 0;

    always #5 clk = ~clk;

    decode_packet dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .decode_valid     (decode_valid),
        .data_recv        (data_recv),
        .ready_decode_pkt (ready_decode_pkt),
        .dfx_valid        (dfx_valid),
        .dfx_ready        (dfx_ready),
        .data_dfx_recv    (data_dfx_recv),
        .dfx_src_router   (dfx_src_router),
        .seq_error        (seq_error)
    );

    always @(negedge clk) begin
        if (dfx_valid) dfx_cycles++;
        if (seq_error) seq_cycles++;
    end

    function automatic logic [54:0] pay(input int k, input logic [7:0] salt);
        logic [55:0] t;
        t = {7{8'(k + 1) ^ salt}};
        return t[54:0];
    endfunction

    function automatic logic [63:0] flit(input int n, input logic [1:0] s, input logic [54:0] p);
        return {p, 2'b11, 5'(n), s};
    endfunction

    function automatic logic [1033:0] build(input logic [7:0] salt);
        logic [1033:0] w;
        logic [54:0]   p;
        w = '0;
        for (int k = 0; k < 18; k++) w[k*55 +: 55] = pay(k, salt);
        p = pay(18, salt);
        w[1033:990] = p[43:0];
        return w;
    endfunction

    function automatic int first_diff(input logic [1033:0] a, input logic [1033:0] b);
        logic [1087:0] pa;
        logic [1087:0] pb;
        pa = {54'd0, a};
        pb = {54'd0, b};
        for (int k = 0; k < 17; k++) if (pa[k*64 +: 64] !== pb[k*64 +: 64]) return k;
        return 0;
    endfunction

    function automatic logic [63:0] chunk(input logic [1033:0] a, input int k);
        logic [1087:0] pa;
        pa = {54'd0, a};
        return pa[k*64 +: 64];
    endfunction

    task automatic send(input logic [63:0] f);
        int b;
        decode_valid = 1'b1;
        data_recv    = f;
        b = 0;
        while (!ready_decode_pkt && b < 60) begin
            @(posedge clk); #1;
            b++;
        end
        if (b >= 60) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: ready_decode_pkt=%0b after %0d cycles, required 1", ready_decode_pkt, b);
        end
        @(posedge clk); #1;
        decode_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] salt, input logic [1:0] src, input int first, input int last, input bit gaps);
        for (int n = first; n <= last; n++) begin
            if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            send(flit(n, src, pay(n, salt)));
        end
    endtask

    task automatic check_word(input string name, input logic [7:0] salt, input logic [1:0] src);
        logic [1033:0] w;
        int d;
        w = build(salt);
        n_chk++;
        if (dfx_valid !== 1'b1) begin
            n_fail++; $display("FAIL %s_valid: got %0b required 1", name, dfx_valid);
        end
        n_chk++;
        if (data_dfx_recv !== w) begin
            d = first_diff(data_dfx_recv, w);
            n_fail++;
            $display("FAIL %s_word: chunk %0d got %h required %h", name, d, chunk(data_dfx_recv, d), chunk(w, d));
        end
        n_chk++;
        if (dfx_src_router !== src) begin
            n_fail++; $display("FAIL %s_src: got %b required %b", name, dfx_src_router, src);
        end
    endtask

    task automatic check_counts(input string name, input int d0, input int dexp, input int s0, input int sexp);
        n_chk++;
        if (dfx_cycles - d0 !== dexp) begin
            n_fail++; $display("FAIL %s_dfx_cycles: got %0d required %0d", name, dfx_cycles - d0, dexp);
        end
        n_chk++;
        if (seq_cycles - s0 !== sexp) begin
            n_fail++; $display("FAIL %s_seq_cycles: got %0d required %0d", name, seq_cycles - s0, sexp);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        n_chk++;
        if (ready_decode_pkt !== 1'b0 || dfx_valid !== 1'b0 || seq_error !== 1'b0 ||
            dfx_src_router !== 2'b00 || data_dfx_recv !== '0) begin
            n_fail++;
            $display("FAIL %s_outputs: rdy=%0b vld=%0b seq=%0b src=%b data_zero=%0b required all 0",
                     name, ready_decode_pkt, dfx_valid, seq_error, dfx_src_router, data_dfx_recv == '0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; decode_valid = 1'b0; data_recv = '0; dfx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if (ready_decode_pkt !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %0b required 1", ready_decode_pkt);
        end
    endtask

    task automatic test_normal();
        int d0, s0;
        d0 = dfx_cycles; s0 = seq_cycles;
        send_frame(8'h00, 2'b01, 0, 18, 1'b0);
        check_word("normal", 8'h00, 2'b01);
        @(posedge clk); #1;
        n_chk++;
        if (dfx_valid !== 1'b0 || ready_decode_pkt !== 1'b1) begin
            n_fail++; $display("FAIL normal_handoff: vld=%0b rdy=%0b required vld=0 rdy=1", dfx_valid, ready_decode_pkt);
        end
        @(posedge clk); #1;
        check_counts("normal", d0, 1, s0, 0);
    endtask

    task automatic test_backpressure();
        int d0, s0;
        logic [1033:0] held;
        d0 = dfx_cycles; s0 = seq_cycles;
        dfx_ready = 1'b0;
        send_frame(8'h5a, 2'b11, 0, 18, 1'b0);
        held = build(8'h5a);
        decode_valid = 1'b1;
        data_recv = flit(0, 2'b10, pay(0, 8'hff));
        for (int i = 0; i < 10; i++) begin
            n_chk++;
            if (dfx_valid !== 1'b1 || ready_decode_pkt !== 1'b0 || data_dfx_recv !== held) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: vld=%0b rdy=%0b data_held=%0b required vld=1 rdy=0 held=1",
                         i, dfx_valid, ready_decode_pkt, data_dfx_recv === held);
            end
            @(posedge clk); #1;
        end
        decode_valid = 1'b0;
        dfx_ready = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if (dfx_valid !== 1'b0 || ready_decode_pkt !== 1'b1) begin
            n_fail++; $display("FAIL bp_handoff: vld=%0b rdy=%0b required vld=0 rdy=1", dfx_valid, ready_decode_pkt);
        end
        @(posedge clk); #1;
        check_counts("bp", d0, 11, s0, 0);
    endtask

    task automatic test_seq_error();
        int d0, s0;
        d0 = dfx_cycles; s0 = seq_cycles;
        send_frame(8'h11, 2'b01, 0, 4, 1'b0);
        send(flit(7, 2'b01, pay(7, 8'h11)));
        n_chk++;
        if (seq_error !== 1'b1) begin
            n_fail++; $display("FAIL seq_pulse: got %0b required 1", seq_error);
        end
        send_frame(8'h22, 2'b01, 0, 18, 1'b0);
        check_word("seq", 8'h22, 2'b01);
        repeat (2) begin @(posedge clk); #1; end
        check_counts("seq", d0, 1, s0, 1);
    endtask

    task automatic test_restart();
        int d0, s0;
        d0 = dfx_cycles; s0 = seq_cycles;
        send_frame(8'h33, 2'b10, 0, 9, 1'b0);
        send_frame(8'h44, 2'b01, 0, 18, 1'b0);
        check_word("restart", 8'h44, 2'b01);
        repeat (2) begin @(posedge clk); #1; end
        check_counts("restart", d0, 1, s0, 1);
    endtask

    task automatic test_src_mismatch();
        int d0, s0;
        d0 = dfx_cycles; s0 = seq_cycles;
        send(flit(0, 2'b01, pay(0, 8'h77)));
        send(flit(1, 2'b10, pay(1, 8'h77)));
        n_chk++;
        if (seq_error !== 1'b1) begin
            n_fail++; $display("FAIL src_pulse: got %0b required 1", seq_error);
        end
        repeat (2) begin @(posedge clk); #1; end
        send(flit(25, 2'b01, pay(25, 8'h77)));
        n_chk++;
        if (seq_error !== 1'b1) begin
            n_fail++; $display("FAIL pkt25_pulse: got %0b required 1", seq_error);
        end
        repeat (3) begin @(posedge clk); #1; end
        n_chk++;
        if (dfx_valid !== 1'b0) begin
            n_fail++; $display("FAIL src_no_valid: got %0b required 0", dfx_valid);
        end
        check_counts("src", d0, 0, s0, 2);
    endtask

    task automatic test_reset_gaps();
        int d0, s0;
        send_frame(8'h55, 2'b01, 0, 11, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("midreset");
        rst_n = 1'b1;
        d0 = dfx_cycles; s0 = seq_cycles;
        send_frame(8'h66, 2'b10, 0, 18, 1'b1);
        check_word("gaps", 8'h66, 2'b10);
        repeat (2) begin @(posedge clk); #1; end
        check_counts("gaps", d0, 1, s0, 0);
    endtask

    initial begin
        test_reset();
        test_normal();
        test_backpressure();
        test_seq_error();
        test_restart();
        test_src_mismatch();
        test_reset_gaps();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_packet.md
Name: decode_packet

Overview:
Receive side of the 4-lane router packetiser. Consumes 64-bit Aurora flits, each carrying {payload, TTL, pkt_number, src_router}, from the lane RX FIFO. Reassembles NUMBER_PACKET consecutive flits into one DATA_DFX_WIDTH-bit DFX word, i.e. data plus address. Hands the word to the decode controller over a valid/ready handshake.

Parameters:
DATA_WIDTH, 1024, data portion of DFX word
ADDR_WIDTH, 10, address portion of DFX word
DATA_DFX_WIDTH, DATA_WIDTH+ADDR_WIDTH (1034), reassembled word width
NUMBER_PACKET, 19, flits per DFX word
AURORA_DATA_WIDTH, 64, flit width
PAYLOAD_WIDTH, 55, payload bits per flit

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
decode_valid  input  1  RX FIFO has a flit on data_recv
data_recv  input  64  flit: [63:9] payload, [8:7] TTL, [6:2] pkt_number, [1:0] src_router
ready_decode_pkt  output  1  block accepts a flit this cycle
dfx_valid  output  1  data_dfx_recv holds a complete word
dfx_ready  input  1  decode controller takes the word
data_dfx_recv  output  1034  reassembled DFX word
dfx_src_router  output  2  src_router of the held word
seq_error  output  1  one-cycle pulse: a bad flit was received

Behaviour:
- One clock; reset is synchronous and active-low on rst_n, sampled at posedge clk, and overrides everything.
- Reset values: ready_decode_pkt=0, dfx_valid=0, data_dfx_recv=0, dfx_src_router=0, seq_error=0, expected index=0, state=COLLECT.
- Flit accept: decode_valid && ready_decode_pkt at a posedge.
- States:
  - COLLECT: ready_decode_pkt=1. It becomes 1 on the first cycle after reset release, and is registered.
  - OUTPUT: ready_decode_pkt=0 and dfx_valid=1.
- Expected index exp (5 bits, 0..NUMBER_PACKET-1). On an accepted flit, with n=pkt_number and s=src_router:
  - Good flit: n==exp, and either exp==0 or s equals the src captured at index 0.
  - Good flit, n<18: write data_recv[63:9] into data_dfx_recv[n*55 +: 55].
  - Good flit, n==18: write data_recv[52:9] into data_dfx_recv[1033:990]. data_recv[63:53] is ignored.
  - Good flit: exp==0 captures s. Then exp increments.
  - Bad flit: seq_error=1 on the next cycle.
  - Bad flit with n==0: treat it as a good index-0 flit. Write the payload, capture s, set exp=1.
  - Bad flit with n!=0: discard it and set exp=0.
  - Any n>=19 is bad.
  - Previously written bits are not cleared on error. data_dfx_recv is meaningful only while dfx_valid=1.
- Completion: good flit n==18 accepted at edge N.
  - At N: state goes to OUTPUT, exp=0, ready_decode_pkt=0 next cycle.
  - From N+1: dfx_valid=1, dfx_src_router=captured src.
  - Latency is 1 cycle from the last flit to dfx_valid.
- OUTPUT: data_dfx_recv and dfx_src_router hold stable until dfx_valid && dfx_ready at edge M. Then dfx_valid=0 and ready_decode_pkt=1 from M+1. No flit is accepted in the cycle of the handoff.
- Gaps (decode_valid=0) between flits are allowed at any length. Partial state is retained.
- TTL is ignored.
- Reset mid-frame: partial frame lost, exp=0, outputs return to reset values; the next frame decodes normally.

Test Plan:
1. Normal frame: reset, then 19 back-to-back flits, pkt_number 0..18, src=2'b01, payload k = 55'h(k+1) repeated pattern, with dfx_ready=1. Required: dfx_valid high exactly 1 cycle, one cycle after flit 18; each 55-bit slice of data_dfx_recv equals its payload; [1033:990] equals flit 18 [52:9]; dfx_src_router=01; seq_error never asserted.
2. Backpressure: frame as in 1 with dfx_ready=0 for 10 cycles. Required: dfx_valid and data held for 10 cycles; ready_decode_pkt=0 and FIFO flits are not consumed. Then dfx_ready=1 gives one handoff, and ready_decode_pkt=1 the next cycle.
3. Sequence error: send flits 0..4, then a flit with pkt_number=7. Required: seq_error pulses once and exp resets. Then a full frame 0..18 gives one dfx_valid with the correct data.
4. Restart on 0: send flits 0..9, then a new 0..18. Required: one seq_error pulse, then one completed word containing only the second frame's payloads.
5. Source mismatch: flit 0 with src=01, flit 1 with src=10. Required: seq_error pulses and no dfx_valid. Flit 25 (pkt_number=25) is also rejected with a seq_error pulse.
6. Reset and gaps: send flits 0..11, assert rst_n=0 for 1 cycle. Required: all outputs return to 0 on the following edge. Then a full frame with random 0-3 cycle decode_valid gaps gives a correct single word.
